// File: rtl/vga_rect_engine.sv
// vga_rect_engine: VGA timing generator that composites a
// double-buffered table of solid rectangles over a background.
// Ports: clk, clr (async, active-high); wr_en/wr_addr/wr_x0..wr_y1/
// wr_color/wr_vis write a shadow slot; bg_color background;
// hsync/vsync, r/g/b, x_pos/y_pos, frame_start are registered outputs.
module vga_rect_engine #(
  parameter int   H_ACTIVE = 640,
  parameter int   H_FP     = 16,
  parameter int   H_SYNC   = 96,
  parameter int   H_BP     = 48,
  parameter int   V_ACTIVE = 480,
  parameter int   V_FP     = 10,
  parameter int   V_SYNC   = 2,
  parameter int   V_BP     = 33,
  parameter int   NUM_RECT = 16,
  parameter int   COLOR_W  = 4,
  parameter logic SYNC_POL = 1'b0
) (
  input  logic                        clk,
  input  logic                        clr,
  input  logic                        wr_en,
  input  logic [$clog2(NUM_RECT)-1:0] wr_addr,
  input  logic [9:0]                  wr_x0,
  input  logic [9:0]                  wr_x1,
  input  logic [9:0]                  wr_y0,
  input  logic [9:0]                  wr_y1,
  input  logic [3*COLOR_W-1:0]        wr_color,
  input  logic                        wr_vis,
  input  logic [3*COLOR_W-1:0]        bg_color,
  output logic                        hsync,
  output logic                        vsync,
  output logic [COLOR_W-1:0]          r,
  output logic [COLOR_W-1:0]          g,
  output logic [COLOR_W-1:0]          b,
  output logic [9:0]                  x_pos,
  output logic [9:0]                  y_pos,
  output logic                        frame_start
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HS_LO   = H_ACTIVE + H_FP;
  localparam int HS_HI   = HS_LO + H_SYNC;
  localparam int VS_LO   = V_ACTIVE + V_FP;
  localparam int VS_HI   = VS_LO + V_SYNC;
  localparam int CW      = 3 * COLOR_W;

  typedef struct packed {
    logic [9:0]    x0;
    logic [9:0]    x1;
    logic [9:0]    y0;
    logic [9:0]    y1;
    logic [CW-1:0] color;
    logic          vis;
  } rect_t;

  logic [9:0]    hcnt_q, hcnt_d;
  logic [9:0]    vcnt_q, vcnt_d;
  logic          h_last, frame_last;
  rect_t         shd_q  [NUM_RECT];
  rect_t         shd_d  [NUM_RECT];
  rect_t         live_q [NUM_RECT];
  rect_t         live_d [NUM_RECT];
  logic [CW-1:0] pix;
  logic          active;
  logic [CW-1:0] rgb_q, rgb_d;
  logic          hs_q, hs_d;
  logic          vs_q, vs_d;
  logic          fs_q, fs_d;
  logic [9:0]    xpos_q, xpos_d;
  logic [9:0]    ypos_q, ypos_d;

  always_comb begin
    h_last     = (hcnt_q == 10'(H_TOTAL - 1));
    frame_last = h_last && (vcnt_q == 10'(V_TOTAL - 1));
    hcnt_d     = h_last ? '0 : hcnt_q + 10'd1;
    vcnt_d     = vcnt_q;
    if (h_last) begin
      vcnt_d = (vcnt_q == 10'(V_TOTAL - 1)) ? '0 : vcnt_q + 10'd1;
    end
  end

  // Live copy takes the pre-edge shadow, so a write landing in the
  // boundary cycle itself waits for the following frame.
  always_comb begin
    shd_d  = shd_q;
    live_d = live_q;
    if (wr_en && (int'(wr_addr) < NUM_RECT)) begin
      shd_d[wr_addr] = {wr_x0, wr_x1, wr_y0, wr_y1, wr_color, wr_vis};
    end
    if (frame_last) begin
      live_d = shd_q;
    end
  end

  // Scan high to low so the lowest hitting slot wins. Empty or
  // inverted bounds fail the half-open compare on their own.
  always_comb begin
    pix = bg_color;
    for (int i = NUM_RECT - 1; i >= 0; i--) begin
      if (live_q[i].vis &&
          hcnt_q >= live_q[i].x0 && hcnt_q < live_q[i].x1 &&
          vcnt_q >= live_q[i].y0 && vcnt_q < live_q[i].y1) begin
        pix = live_q[i].color;
      end
    end
  end

  always_comb begin
    active = (hcnt_q < 10'(H_ACTIVE)) && (vcnt_q < 10'(V_ACTIVE));
    rgb_d  = active ? pix : '0;
    hs_d   = (hcnt_q >= 10'(HS_LO) && hcnt_q < 10'(HS_HI)) ?
             SYNC_POL : ~SYNC_POL;
    vs_d   = (vcnt_q >= 10'(VS_LO) && vcnt_q < 10'(VS_HI)) ?
             SYNC_POL : ~SYNC_POL;
    fs_d   = (hcnt_q == '0) && (vcnt_q == '0);
    xpos_d = hcnt_q;
    ypos_d = vcnt_q;
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      hcnt_q <= '0;
      vcnt_q <= '0;
      for (int i = 0; i < NUM_RECT; i++) begin
        shd_q[i]  <= '0;
        live_q[i] <= '0;
      end
      rgb_q  <= '0;
      hs_q   <= ~SYNC_POL;
      vs_q   <= ~SYNC_POL;
      fs_q   <= 1'b0;
      xpos_q <= '0;
      ypos_q <= '0;
    end else begin
      hcnt_q <= hcnt_d;
      vcnt_q <= vcnt_d;
      for (int i = 0; i < NUM_RECT; i++) begin
        shd_q[i]  <= shd_d[i];
        live_q[i] <= live_d[i];
      end
      rgb_q  <= rgb_d;
      hs_q   <= hs_d;
      vs_q   <= vs_d;
      fs_q   <= fs_d;
      xpos_q <= xpos_d;
      ypos_q <= ypos_d;
    end
  end

  assign r           = rgb_q[CW-1 -: COLOR_W];
  assign g           = rgb_q[2*COLOR_W-1 -: COLOR_W];
  assign b           = rgb_q[COLOR_W-1:0];
  assign hsync       = hs_q;
  assign vsync       = vs_q;
  assign x_pos       = xpos_q;
  assign y_pos       = ypos_q;
  assign frame_start = fs_q;
endmodule

// File: tb/tb_vga_rect_engine.sv
// tb_vga_rect_engine: scoreboard bench for vga_rect_engine on a
// reduced raster; a negedge monitor pops expected pixels by position.
module tb_vga_rect_engine;
  localparam int H_A = 156, H_F = 2, H_S = 3, H_B = 2;
  localparam int V_A = 156, V_F = 1, V_S = 2, V_B = 1;
  localparam int HT = H_A + H_F + H_S + H_B;
  localparam int VT = V_A + V_F + V_S + V_B;
  localparam int FT = HT * VT;

  logic        clk = 1'b0;
  logic        clr, wr_en, wr_vis;
  logic [3:0]  wr_addr;
  logic [9:0]  wr_x0, wr_x1, wr_y0, wr_y1;
  logic [11:0] wr_color, bg_color;
  logic        hs0, vs0, fs0, hs1, vs1, fs1;
  logic [3:0]  r0, g0, b0, r1, g1, b1;
  logic [9:0]  xp0, yp0, xp1, yp1;

  always #5 clk = ~clk;

  vga_rect_engine #(
    .H_ACTIVE(H_A), .H_FP(H_F), .H_SYNC(H_S), .H_BP(H_B),
    .V_ACTIVE(V_A), .V_FP(V_F), .V_SYNC(V_S), .V_BP(V_B),
    .NUM_RECT(16), .COLOR_W(4), .SYNC_POL(1'b0)
  ) dut0 (
    .clk(clk), .clr(clr), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_x0(wr_x0), .wr_x1(wr_x1), .wr_y0(wr_y0), .wr_y1(wr_y1),
    .wr_color(wr_color), .wr_vis(wr_vis), .bg_color(bg_color),
    .hsync(hs0), .vsync(vs0), .r(r0), .g(g0), .b(b0),
    .x_pos(xp0), .y_pos(yp0), .frame_start(fs0)
  );

  vga_rect_engine #(
    .H_ACTIVE(H_A), .H_FP(H_F), .H_SYNC(H_S), .H_BP(H_B),
    .V_ACTIVE(V_A), .V_FP(V_F), .V_SYNC(V_S), .V_BP(V_B),
    .NUM_RECT(16), .COLOR_W(4), .SYNC_POL(1'b1)
  ) dut1 (
    .clk(clk), .clr(clr), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_x0(wr_x0), .wr_x1(wr_x1), .wr_y0(wr_y0), .wr_y1(wr_y1),
    .wr_color(wr_color), .wr_vis(wr_vis), .bg_color(bg_color),
    .hsync(hs1), .vsync(vs1), .r(r1), .g(g1), .b(b1),
    .x_pos(xp1), .y_pos(yp1), .frame_start(fs1)
  );

  typedef struct {
    int          frm;
    int          x;
    int          y;
    logic [11:0] rgb;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   edge_n = 0;
  bit   monitor_on = 1'b0;

  int frm = -1;
  int hs0_cnt = 0, hs0_bad = 0, vs0_cnt = 0, vs0_bad = 0;
  int hs1_cnt = 0, hs1_bad = 0, vs1_cnt = 0, vs1_bad = 0;
  int bg_cnt = 0, blank_bad = 0, fs_cnt = 0;

  task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask

  task automatic px(int f, int x, int y, logic [11:0] c, string n);
    exp_t e;
    e.frm = f; e.x = x; e.y = y; e.rgb = c; e.name = n;
    sb.push_back(e);
  endtask

  always @(negedge clk) begin : mon
    logic [11:0] rgb;
    int          x, y;
    bit          hwin, vwin;
    if (monitor_on) begin
      rgb  = {r0, g0, b0};
      x    = int'(xp0);
      y    = int'(yp0);
      hwin = (x >= H_A + H_F) && (x < H_A + H_F + H_S);
      vwin = (y >= V_A + V_F) && (y < V_A + V_F + V_S);
      if (fs0 === 1'b1) begin
        frm++;
        if (frm == 1) begin
          chk("f0_hs_low_cycles", hs0_cnt, V_S * 0 + VT * H_S);
          chk("f0_hs_low_misplaced", hs0_bad, 0);
          chk("f0_vs_low_cycles", vs0_cnt, V_S * HT);
          chk("f0_vs_low_misplaced", vs0_bad, 0);
          chk("f0_pol1_hs_high_cycles", hs1_cnt, VT * H_S);
          chk("f0_pol1_hs_misplaced", hs1_bad, 0);
          chk("f0_pol1_vs_high_cycles", vs1_cnt, V_S * HT);
          chk("f0_pol1_vs_misplaced", vs1_bad, 0);
          chk("f0_active_bg_pixels", bg_cnt, V_A * H_A);
          chk("f0_blank_nonzero", blank_bad, 0);
          chk("f0_frame_start_cycles", fs_cnt, 1);
        end
        for (int i = sb.size() - 1; i >= 0; i--) begin
          if (sb[i].frm < frm) begin
            checks++;
            errors++;
            $display("FAIL %s: pixel (%0d,%0d) frame %0d not seen, expected %h",
                     sb[i].name, sb[i].x, sb[i].y, sb[i].frm, sb[i].rgb);
            sb.delete(i);
          end
        end
      end
      if (frm == 0) begin
        if (hs0 === 1'b0) begin hs0_cnt++; if (!hwin) hs0_bad++; end
        if (vs0 === 1'b0) begin vs0_cnt++; if (!vwin) vs0_bad++; end
        if (hs1 === 1'b1) begin hs1_cnt++; if (!hwin) hs1_bad++; end
        if (vs1 === 1'b1) begin vs1_cnt++; if (!vwin) vs1_bad++; end
        if (x < H_A && y < V_A) begin
          if (rgb === 12'h00F) bg_cnt++;
        end else if (rgb !== 12'h000) begin
          blank_bad++;
        end
        if (fs0 === 1'b1) fs_cnt++;
      end
      for (int i = 0; i < sb.size(); i++) begin
        if (sb[i].frm == frm && sb[i].x == x && sb[i].y == y) begin
          checks++;
          if (rgb !== sb[i].rgb) begin
            errors++;
            $display("FAIL %s: pixel (%0d,%0d) frame %0d got %h expected %h",
                     sb[i].name, x, y, frm, rgb, sb[i].rgb);
          end
          sb.delete(i);
          break;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    edge_n++;
    #1;
  endtask

  task automatic go_to(int e);
    while (edge_n < e) tick();
  endtask

  task automatic wr(int a, int x0, int x1, int y0, int y1,
                    logic [11:0] c, bit v);
    wr_en    = 1'b1;
    wr_addr  = 4'(a);
    wr_x0    = 10'(x0);
    wr_x1    = 10'(x1);
    wr_y0    = 10'(y0);
    wr_y1    = 10'(y1);
    wr_color = c;
    wr_vis   = v;
    tick();
    wr_en    = 1'b0;
  endtask

  initial begin
    clr = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_vis = 1'b0;
    wr_x0 = '0; wr_x1 = '0; wr_y0 = '0; wr_y1 = '0;
    wr_color = '0; bg_color = 12'h00F;
    #1 clr = 1'b1;
    #1;
    chk("rst_rgb", {r0, g0, b0}, 12'h000);
    chk("rst_hsync_pol0", hs0, 1'b1);
    chk("rst_vsync_pol1", vs1, 1'b0);
    chk("rst_frame_start", fs0, 1'b0);
    repeat (2) @(posedge clk);
    monitor_on = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    edge_n = 0;

    go_to(3 * HT + 20);
    wr(3, 10, 20, 5, 8, 12'hFFF, 1'b1);
    px(0, 15, 6, 12'h00F, "s3_hidden_f0");
    px(1, 10, 5, 12'hFFF, "s3_corner_lo");
    px(1, 15, 6, 12'hFFF, "s3_mid");
    px(1, 19, 7, 12'hFFF, "s3_corner_hi");
    px(1, 20, 5, 12'h00F, "s3_x1_excl");
    px(1, 19, 8, 12'h00F, "s3_y1_excl");
    px(1, 9, 7, 12'h00F, "s3_left_out");
    px(1, 10, 4, 12'h00F, "s3_top_out");
    wr(4, 30, 30, 0, 10, 12'h0F0, 1'b1);
    px(1, 30, 3, 12'h00F, "s4_zero_width");
    wr(5, 40, 50, 12, 3, 12'h0F0, 1'b1);
    px(1, 45, 5, 12'h00F, "s5_inverted_y_a");
    px(1, 45, 12, 12'h00F, "s5_inverted_y_b");
    wr(6, 60, 70, 0, 10, 12'hF0F, 1'b0);
    px(1, 65, 5, 12'h00F, "s6_invisible");

    go_to(FT - 1);
    wr(2, 150, 156, 0, 2, 12'h0FF, 1'b1);
    px(1, 150, 0, 12'h00F, "s2_not_next_a");
    px(1, 155, 1, 12'h00F, "s2_not_next_b");
    px(2, 150, 0, 12'h0FF, "s2_after_a");
    px(2, 155, 1, 12'h0FF, "s2_after_b");
    px(2, 149, 0, 12'h00F, "s2_left_out");
    px(2, 150, 2, 12'h00F, "s2_below_out");

    go_to(FT + 10 * HT);
    wr(0, 0, 100, 0, 100, 12'hF00, 1'b1);
    wr(1, 50, 150, 50, 150, 12'h0F0, 1'b1);
    px(1, 60, 60, 12'h00F, "s01_not_yet");
    px(2, 15, 6, 12'hF00, "s0_over_s3");
    px(2, 60, 60, 12'hF00, "overlap_low_idx");
    px(2, 99, 99, 12'hF00, "s0_last");
    px(2, 100, 100, 12'h0F0, "s1_after_s0");
    px(2, 120, 120, 12'h0F0, "s1_only");
    px(2, 149, 149, 12'h0F0, "s1_last");
    px(2, 150, 149, 12'h00F, "s1_x1_excl");
    px(2, 155, 154, 12'h00F, "no_hit_bg");

    go_to(2 * FT + 155 * HT + 100 + 1);
    foreach (sb[i]) begin
      checks++;
      errors++;
      $display("FAIL %s: pixel (%0d,%0d) frame %0d not seen, expected %h",
               sb[i].name, sb[i].x, sb[i].y, sb[i].frm, sb[i].rgb);
    end
    sb.delete();
    chk("pre_clr_x", xp0, 10'd100);
    chk("pre_clr_y", yp0, 10'd155);
    chk("pre_clr_rgb", {r0, g0, b0}, 12'h00F);
    #2 clr = 1'b1;
    #1;
    chk("async_clr_rgb", {r0, g0, b0}, 12'h000);
    chk("async_clr_x", xp0, 10'd0);
    chk("async_clr_y", yp0, 10'd0);
    chk("async_clr_hs0", hs0, 1'b1);
    chk("async_clr_vs0", vs0, 1'b1);
    chk("async_clr_hs1", hs1, 1'b0);
    chk("async_clr_vs1", vs1, 1'b0);
    chk("async_clr_fs", fs0, 1'b0);
    tick();
    tick();
    chk("held_clr_x", xp0, 10'd0);
    chk("held_clr_fs", fs0, 1'b0);
    @(negedge clk);
    clr = 1'b0;
    #1;
    chk("release_fs_before_edge", fs0, 1'b0);
    @(posedge clk);
    #1;
    chk("first_edge_fs", fs0, 1'b1);
    chk("first_edge_x", xp0, 10'd0);
    chk("first_edge_y", yp0, 10'd0);
    chk("first_edge_slots_cleared", {r0, g0, b0}, 12'h00F);
    @(posedge clk);
    #1;
    chk("second_edge_fs", fs0, 1'b0);
    chk("second_edge_x", xp0, 10'd1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
